// File: rtl/uart_tx_out_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_out_if
// Purpose  : I/O-bus write side plus serial/status outputs of the UART transmitter.
// Revision : 1.0
// ============================================================================
interface uart_tx_out_if;
    logic [15:0] port_id;
    logic [15:0] out_port;
    logic        write_strobe;
    logic        interrupt_ack;
    logic        tx;
    logic        txrdy;
    logic        interrupt;

    modport master (
        output port_id,
        output out_port,
        output write_strobe,
        output interrupt_ack,
        input  tx,
        input  txrdy,
        input  interrupt
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  write_strobe,
        input  interrupt_ack,
        output tx,
        output txrdy,
        output interrupt
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_out.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_out
// Purpose  : Byte-wide 8N1 UART transmitter with sticky frame-done interrupt.
//            Define UART_TX_PARITY_EN to send 8E1 frames instead.
// Revision : 1.0
// ============================================================================
module uart_tx_out #(
    parameter int unsigned BAUD_DIV = 868,
    parameter logic [15:0] TX_PORT  = 16'h0000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    uart_tx_out_if.slave    bus
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    localparam logic [15:0] C_BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shreg;
    logic        r_tx;
    logic        r_txrdy;
    logic        r_irq;
    logic        w_ld;
    logic        w_bit_end;
    logic        w_tx_next;
    logic        w_frame_done;
    logic        unused_hi;

`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    assign unused_hi = ^bus.out_port[15:8];

    assign w_ld      = bus.write_strobe && (bus.port_id == TX_PORT) && r_txrdy;
    assign w_bit_end = (r_baud_cnt == C_BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // TX is registered from the current state, so the line trails the state by one clock.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ld) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_shreg[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_next = r_parity;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shreg    <= 8'd0;
            r_tx       <= 1'b1;
            r_txrdy    <= 1'b1;
            r_irq      <= 1'b0;
        end else begin
            r_tx <= w_tx_next;

            if (w_ld || (r_state == S_IDLE) || w_bit_end) begin
                r_baud_cnt <= 16'd0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end

            if (w_ld) begin
                r_shreg   <= bus.out_port[7:0];
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shreg   <= {1'b0, r_shreg[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_ld) begin
                r_txrdy <= 1'b0;
            end else if (w_frame_done) begin
                r_txrdy <= 1'b1;
            end

            // A set coinciding with an ack takes priority so no completion is lost.
            if (w_frame_done) begin
                r_irq <= 1'b1;
            end else if (bus.interrupt_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_ld) begin
            r_parity <= ^bus.out_port[7:0];
        end
    end
`endif

    assign bus.tx        = r_tx;
    assign bus.txrdy     = r_txrdy;
    assign bus.interrupt = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_out
// Purpose  : Directed self-checking bench for uart_tx_out (BAUD_DIV=4).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_out;

    localparam int unsigned BD      = 4;
    localparam logic [15:0] C_PORT  = 16'h0000;
`ifdef UART_TX_PARITY_EN
    localparam int          FL      = 11 * BD;
`else
    localparam int          FL      = 10 * BD;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    uart_tx_out_if bus ();

    uart_tx_out #(
        .BAUD_DIV (BD),
        .TX_PORT  (C_PORT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Send one byte and follow the line for 'last' clocks after the load edge.
    task automatic send(input logic [7:0] d, input logic par, input int drop_at,
                        input int ack_at, input int last, input logic irq0);
        logic [10:0] fr;
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, par, d, 1'b0};
`else
        fr = {1'b0, 1'b1, d, 1'b0};
        if (par) fr[10] = 1'b0;
`endif
        bus.port_id      = C_PORT;
        bus.out_port     = {8'hC3, d};
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        chk($sformatf("ld_txrdy_%02h", d), bus.txrdy, 1'b0);
        chk($sformatf("ld_tx_%02h", d), bus.tx, 1'b1);
        chk($sformatf("ld_irq_%02h", d), bus.interrupt, irq0);
        for (int c = 1; c <= last; c++) begin
            if (c == drop_at) begin
                bus.out_port     = 16'h00FF;
                bus.write_strobe = 1'b1;
            end
            if (c == ack_at) bus.interrupt_ack = 1'b1;
            @(negedge clk);
            bus.write_strobe  = 1'b0;
            bus.interrupt_ack = 1'b0;
            chk($sformatf("tx_%02h_c%0d", d, c), bus.tx, fr[(c - 1) / BD]);
            if (c == FL - 1) chk($sformatf("busy_%02h", d), bus.txrdy, 1'b0);
            if (c == FL) begin
                chk($sformatf("done_txrdy_%02h", d), bus.txrdy, 1'b1);
                chk($sformatf("done_irq_%02h", d), bus.interrupt, 1'b1);
            end
        end
    endtask

    task automatic ack_and_check(input logic exp);
        bus.interrupt_ack = 1'b1;
        @(negedge clk);
        bus.interrupt_ack = 1'b0;
        chk("ack_irq", bus.interrupt, exp);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst_n             = 1'b0;
        bus.port_id       = 16'h0000;
        bus.out_port      = 16'h0000;
        bus.write_strobe  = 1'b0;
        bus.interrupt_ack = 1'b0;

        // Reset and idle.
        repeat (2) @(negedge clk);
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_txrdy", bus.txrdy, 1'b1);
        chk("rst_irq", bus.interrupt, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", bus.tx, 1'b1);
        chk("idle_txrdy", bus.txrdy, 1'b1);
        chk("idle_irq", bus.interrupt, 1'b0);

        // 0x55, then 0xA3 back-to-back with a dropped 0xFF write; interrupt stays set across ld.
        send(8'h55, 1'b0, 0, 0, FL, 1'b0);
        send(8'hA3, 1'b0, 10, 0, FL, 1'b1);

        ack_and_check(1'b0);

        // Ack on the stop-exit edge: set wins; then a later ack clears; ack at 0 has no effect.
        send(8'h0F, 1'b0, 0, FL, FL, 1'b0);
        ack_and_check(1'b0);
        ack_and_check(1'b0);

        // Write to a different port is ignored.
        bus.port_id      = 16'h0001;
        bus.out_port     = 16'h0000;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        bus.port_id      = C_PORT;
        repeat (2) begin
            @(negedge clk);
            chk("miss_txrdy", bus.txrdy, 1'b1);
            chk("miss_tx", bus.tx, 1'b1);
        end

        // Reset in the middle of a 0x00 frame.
        send(8'h00, 1'b0, 0, 0, 17, 1'b0);
        chk("pre_rst_tx", bus.tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", bus.tx, 1'b1);
        chk("async_rst_txrdy", bus.txrdy, 1'b1);
        chk("async_rst_irq", bus.interrupt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h3C, 1'b0, 0, 0, FL, 1'b0);
        ack_and_check(1'b0);

        // 0x07 has odd weight: parity bit is 1 when parity is compiled in.
        send(8'h07, 1'b1, 0, 0, FL, 1'b0);
        repeat (2) @(negedge clk);
        chk("end_tx", bus.tx, 1'b1);
        chk("end_txrdy", bus.txrdy, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
